gmm_mahal_operand: RTL and testbench

//  Operand-prep stage directly upstream of the GMM-subtract divider. Per pixel and Gaussian

---
 rtl/gmm_pkg.sv | 35 +++
 rtl/gmm_pipe_reg.sv | 43 ++++
 rtl/gmm_mahal_operand.sv | 87 ++++++++
 tb/tb_gmm_mahal_operand.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/gmm_pkg.sv
// Shared widths, clamp constant and operand types for the GMM Mahalanobis datapath.
// No logic; types are reused by the divider wrapper.
// Backpressure: n/a.
package gmm_pkg;
    localparam int PIX_W    = 8;
    localparam int FRAC_W   = 4;
    localparam int NUMER_W  = 17;
    localparam int DENOM_W  = 16;
    localparam int SQ_SHIFT = 6;
    localparam int VAR_MIN  = 16;
    localparam int CNT_W    = 16;

    localparam int MEAN_W = PIX_W + FRAC_W;
    localparam int DIFF_W = MEAN_W + 1;
    localparam int SQ_W   = 2 * MEAN_W;

    typedef struct packed {
        logic [NUMER_W-1:0] numer;
        logic [DENOM_W-1:0] denom;
    } gmm_operand_t;

    typedef struct packed {
        logic [DIFF_W-1:0]  diff;
        logic [DENOM_W-1:0] denom;
    } gmm_s1_t;

    typedef struct packed {
        gmm_operand_t op;
        logic         sat;
    } gmm_s2_t;

    function automatic logic [DENOM_W-1:0] clamp_var(input logic [DENOM_W-1:0] v);
        return (v < DENOM_W'(VAR_MIN)) ? DENOM_W'(VAR_MIN) : v;
    endfunction
endpackage

// File: rtl/gmm_pipe_reg.sv
// Generic valid/ready register slice.
// Latency 1 cycle.
// Backpressure: holds data and valid while downstream stalls; accepts when empty or draining.
module gmm_pipe_reg #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_vld_i,
    input  logic [DATA_W-1:0] in_dat_i,
    output logic              in_rdy_o,
    output logic              out_vld_o,
    output logic [DATA_W-1:0] out_dat_o,
    input  logic              out_rdy_i
);
    logic              vld_q, vld_d;
    logic [DATA_W-1:0] dat_q, dat_d;

    assign in_rdy_o  = !vld_q || out_rdy_i;
    assign out_vld_o = vld_q;
    assign out_dat_o = dat_q;

    always_comb begin
        vld_d = vld_q;
        dat_d = dat_q;
        if (in_rdy_o) begin
            vld_d = in_vld_i;
            if (in_vld_i) begin
                dat_d = in_dat_i;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            vld_q <= 1'b0;
            dat_q <= '0;
        end else begin
            vld_q <= vld_d;
            dat_q <= dat_d;
        end
    end
endmodule

// File: rtl/gmm_mahal_operand.sv
// Forms the saturated squared-distance numerator and clamped variance for the GMM divider.
// Latency 2 cycles, 1 operand per cycle.
// Backpressure: src_ready stalls S2, then S1, then snk_ready; bubbles collapse.
module gmm_mahal_operand
    import gmm_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               snk_valid,
    input  logic [PIX_W-1:0]   snk_pixel,
    input  logic [MEAN_W-1:0]  snk_mean,
    input  logic [DENOM_W-1:0] snk_var,
    output logic               snk_ready,
    output logic               src_valid,
    output logic [NUMER_W-1:0] src_numer,
    output logic [DENOM_W-1:0] src_denom,
    input  logic               src_ready,
    input  logic               clr_cnt,
    output logic [CNT_W-1:0]   sat_cnt
);
    gmm_s1_t           s1_in, s1_q;
    gmm_s2_t           s2_in, s2_q;
    logic              s1_vld, s2_rdy;
    logic [DIFF_W-1:0] px_ext, mean_ext;
    logic [MEAN_W-1:0] mag;
    logic [SQ_W-1:0]   sq, sq_sh;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    // S1 input: signed difference in one extra bit, variance floor.
    assign px_ext       = {1'b0, snk_pixel, {FRAC_W{1'b0}}};
    assign mean_ext     = {1'b0, snk_mean};
    assign s1_in.diff   = px_ext - mean_ext;
    assign s1_in.denom  = clamp_var(snk_var);

    gmm_pipe_reg #(.DATA_W($bits(gmm_s1_t))) u_s1 (
        .clk       (clk),
        .rst       (rst),
        .in_vld_i  (snk_valid),
        .in_dat_i  (s1_in),
        .in_rdy_o  (snk_ready),
        .out_vld_o (s1_vld),
        .out_dat_o (s1_q),
        .out_rdy_i (s2_rdy)
    );

    // |diff| never exceeds 2^MEAN_W-1, so squaring the magnitude fits SQ_W bits.
    assign mag   = s1_q.diff[DIFF_W-1] ? MEAN_W'(-s1_q.diff) : s1_q.diff[MEAN_W-1:0];
    assign sq    = SQ_W'(mag) * SQ_W'(mag);
    assign sq_sh = sq >> SQ_SHIFT;

    assign s2_in.sat      = |sq_sh[SQ_W-1:NUMER_W];
    assign s2_in.op.numer = s2_in.sat ? {NUMER_W{1'b1}} : sq_sh[NUMER_W-1:0];
    assign s2_in.op.denom = s1_q.denom;

    gmm_pipe_reg #(.DATA_W($bits(gmm_s2_t))) u_s2 (
        .clk       (clk),
        .rst       (rst),
        .in_vld_i  (s1_vld),
        .in_dat_i  (s2_in),
        .in_rdy_o  (s2_rdy),
        .out_vld_o (src_valid),
        .out_dat_o (s2_q),
        .out_rdy_i (src_ready)
    );

    assign src_numer = s2_q.op.numer;
    assign src_denom = s2_q.op.denom;
    assign sat_cnt   = cnt_q;

    // Clear takes priority over a same-cycle saturated transfer.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_cnt) begin
            cnt_d = '0;
        end else if (src_valid && src_ready && s2_q.sat && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: tb/tb_gmm_mahal_operand.sv
module tb_gmm_mahal_operand;
    typedef struct packed {
        logic [16:0] numer;
        logic [15:0] denom;
        logic        sat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        snk_valid = 1'b0;
    logic [7:0]  snk_pixel = '0;
    logic [11:0] snk_mean = '0;
    logic [15:0] snk_var = '0;
    logic        snk_ready;
    logic        src_valid;
    logic [16:0] src_numer;
    logic [15:0] src_denom;
    logic        src_ready = 1'b1;
    logic        clr_cnt = 1'b0;
    logic [15:0] sat_cnt;

    gmm_mahal_operand dut (
        .clk       (clk),
        .rst       (rst),
        .snk_valid (snk_valid),
        .snk_pixel (snk_pixel),
        .snk_mean  (snk_mean),
        .snk_var   (snk_var),
        .snk_ready (snk_ready),
        .src_valid (src_valid),
        .src_numer (src_numer),
        .src_denom (src_denom),
        .src_ready (src_ready),
        .clr_cnt   (clr_cnt),
        .sat_cnt   (sat_cnt)
    );

    always #5 clk = ~clk;

    exp_t        sb[$];
    exp_t        e;
    int          total = 0;
    int          bad = 0;
    int          accepted = 0;
    int unsigned exp_cnt = 0;
    bit          cnt_chk = 1'b0;
    bit          prev_stall = 1'b0;
    bit          bump;
    logic [16:0] prev_numer;
    logic [15:0] prev_denom;

    // Hand-computed vectors: pixel, mean, var -> numer, denom, saturated.
    localparam int NV = 9;
    logic [7:0]  v_pix [NV] = '{8'd100, 8'd110, 8'd255, 8'd0, 8'd181, 8'd182, 8'd0, 8'd50, 8'd200};
    logic [11:0] v_mean[NV] = '{12'd1600, 12'd1600, 12'd0, 12'd4095, 12'd0, 12'd15, 12'd8, 12'd700, 12'd3000};
    logic [15:0] v_var [NV] = '{16'd500, 16'd5, 16'd1000, 16'd16, 16'd100, 16'd17, 16'd15, 16'd16, 16'd65535};
    logic [16:0] v_num [NV] = '{17'd0, 17'd400, 17'd131071, 17'd131071, 17'd131044, 17'd131071, 17'd1, 17'd156, 17'd625};
    logic [15:0] v_den [NV] = '{16'd500, 16'd16, 16'd1000, 16'd16, 16'd100, 16'd17, 16'd16, 16'd16, 16'd65535};
    bit          v_sat [NV] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic send(input int idx);
        bit acc = 1'b0;
        snk_valid = 1'b1;
        snk_pixel = v_pix[idx];
        snk_mean  = v_mean[idx];
        snk_var   = v_var[idx];
        for (int i = 0; i < 1000 && !acc; i++) begin
            @(negedge clk);
            acc = snk_ready;
            @(posedge clk);
            #1;
        end
        if (acc) begin
            sb.push_back('{numer: v_num[idx], denom: v_den[idx], sat: v_sat[idx]});
            accepted++;
        end else begin
            total++;
            bad++;
            $display("FAIL send_timeout idx=%0d actual=not_accepted required=accepted", idx);
        end
    endtask

    task automatic idle();
        snk_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((sb.size() != 0 || src_valid) && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        total++;
        if (sb.size() != 0 || src_valid) begin
            bad++;
            $display("FAIL %s_drain actual=pending%0d required=0", name, sb.size());
        end
    endtask

    // Monitor: pops the scoreboard on every src transfer and tracks the expected counter.
    always @(negedge clk) begin
        bump = 1'b0;
        if (cnt_chk) check("sat_cnt", sat_cnt, exp_cnt);
        if (rst) begin
            if (prev_stall) begin
                check("stall_vld", src_valid, 1);
                check("stall_numer", src_numer, prev_numer);
                check("stall_denom", src_denom, prev_denom);
            end
            if (src_valid && src_ready) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_out actual=numer%0d/denom%0d required=none", src_numer, src_denom);
                end else begin
                    e = sb.pop_front();
                    check("numer", src_numer, e.numer);
                    check("denom", src_denom, e.denom);
                    bump = e.sat;
                end
            end
            prev_stall = src_valid && !src_ready;
            prev_numer = src_numer;
            prev_denom = src_denom;
        end else begin
            prev_stall = 1'b0;
        end
        if (!rst || clr_cnt) exp_cnt = 0;
        else if (bump && exp_cnt < 65535) exp_cnt++;
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        cnt_chk = 1'b1;
        @(negedge clk);
        check("rst_src_valid", src_valid, 0);
        check("rst_numer", src_numer, 0);
        check("rst_denom", src_denom, 0);
        check("rst_sat_cnt", sat_cnt, 0);
        check("rst_snk_ready", snk_ready, 1);
        @(posedge clk);
        #1;

        // Latency: accepted at edge k, visible after edge k+1.
        send(0);
        idle();
        check("lat1_vld", src_valid, 0);
        @(posedge clk);
        #1;
        check("lat2_vld", src_valid, 1);
        drain("lat");

        for (int i = 1; i < NV; i++) send(i);
        idle();
        drain("stream");

        // Three back-to-back inputs against a 5-cycle stall.
        src_ready = 1'b0;
        accepted = 0;
        fork
            begin
                send(4);
                send(5);
                send(6);
                idle();
            end
            begin
                repeat (5) @(posedge clk);
                #2;
                check("bp_accepted", accepted, 2);
                check("bp_snk_ready", snk_ready, 0);
                src_ready = 1'b1;
            end
        join
        drain("bp");

        // Valid offered while not ready, then withdrawn: must not be taken.
        src_ready = 1'b0;
        send(8);
        send(7);
        snk_valid = 1'b1;
        snk_pixel = 8'd255;
        snk_mean  = 12'd0;
        snk_var   = 16'd1;
        repeat (2) begin
            @(posedge clk);
            #2;
            check("withdraw_snk_ready", snk_ready, 0);
        end
        idle();
        src_ready = 1'b1;
        drain("withdraw");

        // Reset with both stages full.
        src_ready = 1'b0;
        send(2);
        send(3);
        idle();
        rst = 1'b0;
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b1;
        check("midrst_src_valid", src_valid, 0);
        check("midrst_sat_cnt", sat_cnt, 0);
        check("midrst_snk_ready", snk_ready, 1);
        src_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        // Clear colliding with a saturated transfer.
        send(2);
        idle();
        drain("presat");
        check("presat_cnt", sat_cnt, 1);
        src_ready = 1'b0;
        send(5);
        idle();
        @(posedge clk);
        #1;
        check("clr_src_valid", src_valid, 1);
        clr_cnt = 1'b1;
        src_ready = 1'b1;
        @(posedge clk);
        #1;
        clr_cnt = 1'b0;
        check("clr_wins", sat_cnt, 0);
        drain("clr");

        // Counter saturation.
        for (int i = 0; i < 65536; i++) send(3);
        idle();
        drain("cntsat");
        check("cnt_saturated", sat_cnt, 65535);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
